// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the RAM arbiter: cpu memory command encodings,
//   arbiter FSM state encodings, the grant owner type and a small helper that
//   decides whether a cpu command is a real access.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   // cpu memory port command; 2'b11 is unused and behaves like MEM_NONE
   typedef enum logic [1:0] {
      MEM_NONE  = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } mem_cmd_e;

   // IDLE is the issue cycle, CPU/DMA are the completion cycles
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_CPU  = 2'b01,
      ARB_DMA  = 2'b10
   } arb_state_e;

   // owner of the most recent grant
   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_DMA = 1'b1
   } grant_e;

   function automatic logic cmd_valid(input logic [1:0] cmd);
      return (cmd == MEM_READ) || (cmd == MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// -----------------------------------------------------------------------------
// mem_arb_rr2
//   Combinational two-way weighted round-robin pick between the cpu and the
//   dma requester. A lone request always wins. On a tie the cpu wins if the
//   dma owned the previous grant, or if the cpu has had fewer than CPU_WEIGHT
//   consecutive grants; otherwise the dma wins.
// Ports
//   cpu_req_i     cpu has a valid command
//   dma_req_i     dma has a pending request
//   last_grant_i  owner of the previous grant
//   cpu_run_i     consecutive cpu grants while the dma was waiting
//   grant_cpu_o   cpu wins this issue cycle
//   grant_dma_o   dma wins this issue cycle
// -----------------------------------------------------------------------------
module mem_arb_rr2
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned CPU_WEIGHT = 2,
   parameter int unsigned RUN_W      = $clog2(CPU_WEIGHT + 1)
) (
   input  logic             cpu_req_i,
   input  logic             dma_req_i,
   input  grant_e           last_grant_i,
   input  logic [RUN_W-1:0] cpu_run_i,
   output logic             grant_cpu_o,
   output logic             grant_dma_o
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CPU_WEIGHT);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else can leave it unassigned and infer a latch.
   always_comb begin
      grant_cpu_o = 1'b0;
      grant_dma_o = 1'b0;
      if (cpu_req_i && dma_req_i) begin
         if ((last_grant_i == GRANT_DMA) || (cpu_run_i < RUN_MAX)) begin
            grant_cpu_o = 1'b1;
         end else begin
            grant_dma_o = 1'b1;
         end
      end else begin
         grant_cpu_o = cpu_req_i;
         grant_dma_o = dma_req_i;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous RAM (1-cycle read latency) between the
//   cpu memory port and a dma/loader requester. Each access takes an issue
//   cycle (IDLE) and a completion cycle (CPU/DMA), so at most one access every
//   two cycles. The cpu is stalled through cpu_wait until its completion cycle;
//   the dma gets a one-cycle dma_ack. Read data is passed through during the
//   completion cycle and held in a per-requester register afterwards.
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cpu_cmd/addr/wdata    cpu command (NONE/READ/WRITE), address, write data
//   cpu_rdata, cpu_wait   cpu read data, stall while the access is pending
//   dma_req/we/addr/wdata dma request held stable until dma_ack
//   dma_ack, dma_rdata    dma completion pulse and read data
//   ram_addr/write/din    RAM address, write enable, write data
//   ram_dout              RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned AW         = 9,
   parameter int unsigned DW         = 16,
   parameter int unsigned CPU_WEIGHT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_cmd,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_wait,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_write,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   localparam int unsigned      RUN_W   = $clog2(CPU_WEIGHT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CPU_WEIGHT);

   arb_state_e       state_q,      state_d;
   grant_e           last_grant_q, last_grant_d;
   logic [RUN_W-1:0] cpu_run_q,    cpu_run_d;
   logic [DW-1:0]    cpu_rdata_q,  cpu_rdata_d;
   logic [DW-1:0]    dma_rdata_q,  dma_rdata_d;

   logic cpu_req;
   logic cpu_is_write;
   logic grant_cpu;
   logic grant_dma;
   logic issue_cpu;
   logic issue_dma;

   assign cpu_req      = cmd_valid(cpu_cmd);
   assign cpu_is_write = (cpu_cmd == MEM_WRITE);

   mem_arb_rr2 #(
      .CPU_WEIGHT (CPU_WEIGHT),
      .RUN_W      (RUN_W)
   ) u_rr2 (
      .cpu_req_i    (cpu_req),
      .dma_req_i    (dma_req),
      .last_grant_i (last_grant_q),
      .cpu_run_i    (cpu_run_q),
      .grant_cpu_o  (grant_cpu),
      .grant_dma_o  (grant_dma)
   );

   // grants only take effect in the issue cycle
   assign issue_cpu = (state_q == ARB_IDLE) && grant_cpu;
   assign issue_dma = (state_q == ARB_IDLE) && grant_dma;

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cpu_run_d    = cpu_run_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (issue_cpu) begin
               state_d      = ARB_CPU;
               last_grant_d = GRANT_CPU;
               if (cpu_run_q != RUN_MAX) begin
                  cpu_run_d = cpu_run_q + RUN_W'(1);
               end
            end else if (issue_dma) begin
               state_d      = ARB_DMA;
               last_grant_d = GRANT_DMA;
               cpu_run_d    = '0;
            end
            // the cpu run only matters while the dma is actually waiting
            if (!dma_req) begin
               cpu_run_d = '0;
            end
         end
         ARB_CPU: begin
            state_d     = ARB_IDLE;
            cpu_rdata_d = ram_dout;
         end
         ARB_DMA: begin
            state_d     = ARB_IDLE;
            dma_rdata_d = ram_dout;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // -------------------------------------------------------------- state regs
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values and simulation matches the
   // synthesized flops regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= GRANT_DMA;   // cpu wins the first tie after reset
         cpu_run_q    <= '0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cpu_run_q    <= cpu_run_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   // ------------------------------------------------------------------ outputs
   // Outputs are gated by reset directly so an asserted reset kills a write or
   // a completion in the same cycle, without waiting for a clock edge.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_din   = cpu_wdata;
      ram_write = 1'b0;
      if (issue_dma) begin
         ram_addr = dma_addr;
         ram_din  = dma_wdata;
      end
      if (reset) begin
         ram_write = (issue_cpu && cpu_is_write) || (issue_dma && dma_we);
      end
   end

   assign cpu_wait  = reset && cpu_req && (state_q != ARB_CPU);
   assign dma_ack   = reset && (state_q == ARB_DMA);
   assign cpu_rdata = (state_q == ARB_CPU) ? ram_dout : cpu_rdata_q;
   assign dma_rdata = (state_q == ARB_DMA) ? ram_dout : dma_rdata_q;

endmodule
